// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_pkg
// Description : Shared UART TX framer types and parity-type constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_frame_if.sv
`default_nettype none
// ============================================================================
// Interface   : uart_tx_frame_if
// Description : Parallel-word handshake and serial line of the UART TX framer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  BUSY;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        input  TX_OUT, BUSY
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        output TX_OUT, BUSY
    );
endinterface : uart_tx_frame_if
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : Holding register and bit counter selecting the current data bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic                  CLK,
    input  wire logic                  RST,
    input  wire logic                  load,
    input  wire logic                  shift_en,
    input  wire logic [DATA_WIDTH-1:0] data_in,
    output logic                       ser_bit,
    output logic                       ser_done
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_hold;
    logic [CW-1:0]         r_cnt;

    // The word is kept unshifted; the counter indexes it and saturates on the last bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hold <= '0;
            r_cnt  <= '0;
        end else if (load) begin
            r_hold <= data_in;
            r_cnt  <= '0;
        end else if (shift_en && (r_cnt != c_LAST)) begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    assign ser_bit  = r_hold[r_cnt];
    assign ser_done = (r_cnt == c_LAST);

endmodule : uart_tx_serializer
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : UART transmit framer: start, LSB-first data, optional parity, stop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    uart_tx_frame_if.slave    bus
);
    import uart_pkg::*;

    tx_state_e r_state;
    tx_state_e w_next_state;

    logic r_par_en;
    logic r_par_typ;
    logic r_par_acc;
    logic r_tx;
    logic r_busy;

    logic w_accept;
    logic w_shift_en;
    logic w_ser_bit;
    logic w_ser_done;
    logic w_tx_next;

    assign w_accept   = bus.DATA_VALID && ((r_state == TX_IDLE) || (r_state == TX_STOP));
    assign w_shift_en = (r_state == TX_DATA);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (w_accept),
        .shift_en (w_shift_en),
        .data_in  (bus.P_DATA),
        .ser_bit  (w_ser_bit),
        .ser_done (w_ser_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_tx_next    = 1'b1;
        unique case (r_state)
            TX_IDLE: begin
                if (w_accept) w_next_state = TX_START;
            end
            TX_START: begin
                w_next_state = TX_DATA;
                w_tx_next    = 1'b0;
            end
            TX_DATA: begin
                w_tx_next = w_ser_bit;
                if (w_ser_done) w_next_state = r_par_en ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                w_next_state = TX_STOP;
                w_tx_next    = r_par_acc;
            end
            TX_STOP: begin
                w_next_state = w_accept ? TX_START : TX_IDLE;
            end
            default: begin
                w_next_state = TX_IDLE;
            end
        endcase
    end

    // Parity accumulates over the transmitted bits, seeded with 1 for odd parity.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_par_en  <= 1'b0;
            r_par_typ <= PAR_EVEN;
            r_par_acc <= 1'b0;
        end else if (w_accept) begin
            r_par_en  <= bus.PAR_EN;
            r_par_typ <= bus.PAR_TYP;
            r_par_acc <= (bus.PAR_TYP == PAR_ODD);
        end else if (w_shift_en) begin
            r_par_acc <= r_par_acc ^ w_ser_bit;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_tx   <= w_tx_next;
            r_busy <= (r_state != TX_IDLE);
        end
    end

    assign bus.TX_OUT = r_tx;
    assign bus.BUSY   = r_busy;

endmodule : uart_tx_frame
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame
// Description : Directed self-checking bench for the UART TX framer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame vectors are {stop, [parity], data, start}; bit i is the i-th bit on the line.
    task automatic expect_line(input logic [15:0] f, input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk); #1;
            chk($sformatf("%s tx bit%0d", tag, i), {15'd0, bus.TX_OUT}, {15'd0, f[i]});
            chk($sformatf("%s busy bit%0d", tag, i), {15'd0, bus.BUSY}, 16'd1);
        end
    endtask

    task automatic expect_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            chk($sformatf("%s idle tx %0d", tag, i), {15'd0, bus.TX_OUT}, 16'd1);
            chk($sformatf("%s idle busy %0d", tag, i), {15'd0, bus.BUSY}, 16'd0);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic hold,
                        input string tag);
        @(negedge clk);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.DATA_VALID = 1'b1;
        @(negedge clk); #1;
        chk({tag, " latency tx"}, {15'd0, bus.TX_OUT}, 16'd1);
        chk({tag, " latency busy"}, {15'd0, bus.BUSY}, 16'd0);
        if (!hold) bus.DATA_VALID = 1'b0;
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        bus.P_DATA     = 8'h00;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset tx", {15'd0, bus.TX_OUT}, 16'd1);
        chk("reset busy", {15'd0, bus.BUSY}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_idle(2, "post-reset");

        // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
        send(8'hA5, 1'b1, 1'b0, 1'b0, "a5");
        expect_line(16'(11'b1_0_10100101_0), 0, 10, "a5");
        expect_idle(2, "a5");

        send(8'h01, 1'b1, 1'b1, 1'b0, "01odd");
        expect_line(16'(11'b1_0_00000001_0), 0, 10, "01odd");
        expect_idle(1, "01odd");
        send(8'h01, 1'b1, 1'b0, 1'b0, "01even");
        expect_line(16'(11'b1_1_00000001_0), 0, 10, "01even");
        expect_idle(1, "01even");

        send(8'hFF, 1'b0, 1'b0, 1'b0, "ff");
        expect_line(16'(10'b1_11111111_0), 0, 9, "ff");
        expect_idle(2, "ff");

        // Valid held high; the second word is presented long before the stop bit.
        send(8'h3C, 1'b0, 1'b0, 1'b1, "b2b");
        bus.P_DATA = 8'hC3;
        expect_line(16'(10'b1_00111100_0), 0, 9, "b2b-3c");
        bus.DATA_VALID = 1'b0;
        expect_line(16'(10'b1_11000011_0), 0, 9, "b2b-c3");
        expect_idle(2, "b2b");

        // 0x55 pulsed while data bit 3 of 0x0F is being sent must be dropped.
        send(8'h0F, 1'b0, 1'b0, 1'b0, "drop");
        expect_line(16'(10'b1_00001111_0), 0, 3, "drop");
        bus.P_DATA     = 8'h55;
        bus.DATA_VALID = 1'b1;
        expect_line(16'(10'b1_00001111_0), 4, 4, "drop");
        bus.DATA_VALID = 1'b0;
        expect_line(16'(10'b1_00001111_0), 5, 9, "drop");
        expect_idle(12, "drop");

        // Reset in the middle of a zero-data frame must force the line high at once.
        send(8'h00, 1'b0, 1'b0, 1'b0, "rst");
        expect_line(16'(10'b1_00000000_0), 0, 4, "rst");
        #1 rst = 1'b1;
        #1;
        chk("async rst tx", {15'd0, bus.TX_OUT}, 16'd1);
        chk("async rst busy", {15'd0, bus.BUSY}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_idle(3, "after-rst");
        send(8'hA5, 1'b1, 1'b0, 1'b0, "rst-a5");
        expect_line(16'(11'b1_0_10100101_0), 0, 10, "rst-a5");
        expect_idle(2, "rst-a5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_uart_tx_frame
`default_nettype wire
